// File: rtl/top_entity_pkg.sv
// Shared types and constants for the stream evaluator: queue entry, 64-bit stream type, stream indices.
// Arithmetic helper saturates when SATURATE_EN is defined, wraps otherwise.
package top_entity_pkg;

    typedef logic signed [63:0] stream_t;

    localparam int PERIOD_CYCLES_DEF = 1000;
    localparam int QDEPTH_DEF        = 4;

    localparam int NUM_OUT = 7;
    localparam int S_OUT0  = 0;
    localparam int S_OUT1  = 1;
    localparam int S_OUT2  = 2;
    localparam int S_OUT3  = 3;
    localparam int S_OUT4  = 4;
    localparam int S_OUT5  = 5;
    localparam int S_OUT6  = 6;

    typedef struct packed {
        stream_t a;
        stream_t b;
        logic    has_a;
        logic    has_b;
        logic    tick;
    } q_entry_t;

    function automatic stream_t s_add(input stream_t x, input stream_t y);
        stream_t sum;
        sum = x + y;
`ifdef SATURATE_EN
        // Overflow only when both operands share a sign the result lost.
        if ((x[63] == y[63]) && (sum[63] != x[63]))
            sum = x[63] ? {1'b1, {63{1'b0}}} : {1'b0, {63{1'b1}}};
`endif
        return sum;
    endfunction

endpackage

// File: rtl/event_queue.sv
// Small FIFO of pending evaluation slots; a push into a full queue is accepted only
// when a pop frees an entry in the same cycle.
module event_queue
    import top_entity_pkg::*;
#(
    parameter int DEPTH = QDEPTH_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  q_entry_t push_data,
    output logic     push_valid,
    input  logic     pop,
    output logic     pop_valid,
    output q_entry_t pop_data
);

    localparam int              AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]   LAST  = AW'(DEPTH - 1);
    localparam logic [AW:0]     FULL  = (AW + 1)'(DEPTH);

    q_entry_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    assign pop_valid  = pop && (count_reg != '0);
    assign push_valid = push && ((count_reg != FULL) || pop_valid);
    assign pop_data   = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_valid)
            mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_valid)
                wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
            if (pop_valid)
                rd_ptr_reg <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + 1'b1;
            case ({push_valid, pop_valid})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/top_entity.sv
// Periodic/event-driven stream evaluator: tick counter, event queue and slot evaluator.
// Define SATURATE_EN for saturating adds instead of wrap-around.
module top_entity
    import top_entity_pkg::*;
#(
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
    parameter int QDEPTH        = QDEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [63:0] input_0,
    input  logic               new_input_0,
    input  logic signed [63:0] input_1,
    input  logic               new_input_1,
    output logic signed [63:0] output_0,
    output logic signed [63:0] output_1,
    output logic signed [63:0] output_2,
    output logic signed [63:0] output_3,
    output logic signed [63:0] output_4,
    output logic signed [63:0] output_5,
    output logic signed [63:0] output_6,
    output logic               output_0_aktv,
    output logic               output_1_aktv,
    output logic               output_2_aktv,
    output logic               output_3_aktv,
    output logic               output_4_aktv,
    output logic               output_5_aktv,
    output logic               output_6_aktv,
    output logic               q_push,
    output logic               q_pop,
    output logic               q_push_valid,
    output logic               q_pop_valid,
    output logic               pacing_in0,
    output logic               pacing_in1,
    output logic               pacing_out0_0,
    output logic               pacing_out1_0,
    output logic               pacing_out2_0,
    output logic               pacing_out3_0,
    output logic               pacing_out3_1,
    output logic               pacing_out4_0,
    output logic               pacing_out5_0,
    output logic               pacing_out6_0
);

    localparam int            CW       = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYCLES - 1);

    logic               active;
    logic               tick;
    logic [CW-1:0]      cnt_reg;
    logic               push;
    logic               push_valid;
    logic               pop_valid;
    q_entry_t           push_data;
    q_entry_t           head;
    logic               pa;
    logic               pb;
    logic               pt;
    stream_t            val_reg [NUM_OUT];
    stream_t            cur [NUM_OUT];
    logic [NUM_OUT-1:0] aktv_reg;
    logic [NUM_OUT-1:0] aktv_next;

    assign active = rst && en;
    assign tick   = active && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_reg <= '0;
        else if (en)
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
    end

    assign push      = active && (new_input_0 || new_input_1 || tick);
    assign push_data = '{a: input_0, b: input_1, has_a: new_input_0,
                         has_b: new_input_1, tick: tick};

    event_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .push_valid (push_valid),
        .pop        (active),
        .pop_valid  (pop_valid),
        .pop_data   (head)
    );

    assign q_push       = push;
    assign q_pop        = active;
    assign q_push_valid = push_valid;
    assign q_pop_valid  = pop_valid;

    assign pa = pop_valid && head.has_a;
    assign pb = pop_valid && head.has_b;
    assign pt = pop_valid && head.tick;

    assign pacing_in0    = pa;
    assign pacing_in1    = pb;
    assign pacing_out0_0 = pa;
    assign pacing_out1_0 = pb;
    assign pacing_out2_0 = pa && pb;
    assign pacing_out3_0 = pa;
    assign pacing_out3_1 = pt;
    assign pacing_out4_0 = pt;
    assign pacing_out5_0 = pt;
    assign pacing_out6_0 = pt;

    // cur starts as the committed values and is overwritten stream by stream, so each
    // read sees this slot's result if already evaluated, else the last committed one.
    always_comb begin
        cur = val_reg;
        if (pa)
            cur[S_OUT0] = s_add(head.a, cur[S_OUT4]);
        if (pb)
            cur[S_OUT1] = s_add(head.b, cur[S_OUT0]);
        if (pa && pb)
            cur[S_OUT2] = s_add(cur[S_OUT0], cur[S_OUT1]);
        if (pa)
            cur[S_OUT3] = s_add(head.a, cur[S_OUT6]);
        else if (pt)
            cur[S_OUT3] = s_add(cur[S_OUT2], cur[S_OUT6]);
        if (pt) begin
            cur[S_OUT4] = s_add(cur[S_OUT3], 64'sd1);
            cur[S_OUT5] = s_add(cur[S_OUT4], cur[S_OUT4]);
            cur[S_OUT6] = s_add(cur[S_OUT5], cur[S_OUT1]);
        end
    end

    always_comb begin
        aktv_next         = '0;
        aktv_next[S_OUT0] = pa;
        aktv_next[S_OUT1] = pb;
        aktv_next[S_OUT2] = pa && pb;
        aktv_next[S_OUT3] = pa || pt;
        aktv_next[S_OUT4] = pt;
        aktv_next[S_OUT5] = pt;
        aktv_next[S_OUT6] = pt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            val_reg  <= '{default: '0};
            aktv_reg <= '0;
        end else if (en) begin
            val_reg  <= cur;
            aktv_reg <= aktv_next;
        end else begin
            aktv_reg <= '0;
        end
    end

    assign output_0 = val_reg[S_OUT0];
    assign output_1 = val_reg[S_OUT1];
    assign output_2 = val_reg[S_OUT2];
    assign output_3 = val_reg[S_OUT3];
    assign output_4 = val_reg[S_OUT4];
    assign output_5 = val_reg[S_OUT5];
    assign output_6 = val_reg[S_OUT6];

    assign output_0_aktv = aktv_reg[S_OUT0] && en;
    assign output_1_aktv = aktv_reg[S_OUT1] && en;
    assign output_2_aktv = aktv_reg[S_OUT2] && en;
    assign output_3_aktv = aktv_reg[S_OUT3] && en;
    assign output_4_aktv = aktv_reg[S_OUT4] && en;
    assign output_5_aktv = aktv_reg[S_OUT5] && en;
    assign output_6_aktv = aktv_reg[S_OUT6] && en;

endmodule

// File: tb/tb_top_entity.sv
// Randomized bench for top_entity against a slot-level behavioural model, plus literal
// expectations for the documented scenarios (honours SATURATE_EN).
module tb_top_entity;

    localparam int     P    = 1000;
    localparam int     QD   = 4;
    localparam longint SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam longint SMIN = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst, en;
    logic signed [63:0] input_0, input_1;
    logic new_input_0, new_input_1;
    wire signed [63:0] o [7];
    wire [6:0] ak;
    wire q_push, q_pop, q_push_valid, q_pop_valid;
    wire pin0, pin1, p00, p10, p20, p30, p31, p40, p50, p60;

    always #5 clk = ~clk;

    top_entity #(.PERIOD_CYCLES(P), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .en(en),
        .input_0(input_0), .new_input_0(new_input_0),
        .input_1(input_1), .new_input_1(new_input_1),
        .output_0(o[0]), .output_1(o[1]), .output_2(o[2]), .output_3(o[3]),
        .output_4(o[4]), .output_5(o[5]), .output_6(o[6]),
        .output_0_aktv(ak[0]), .output_1_aktv(ak[1]), .output_2_aktv(ak[2]),
        .output_3_aktv(ak[3]), .output_4_aktv(ak[4]), .output_5_aktv(ak[5]),
        .output_6_aktv(ak[6]),
        .q_push(q_push), .q_pop(q_pop), .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
        .pacing_in0(pin0), .pacing_in1(pin1), .pacing_out0_0(p00), .pacing_out1_0(p10),
        .pacing_out2_0(p20), .pacing_out3_0(p30), .pacing_out3_1(p31),
        .pacing_out4_0(p40), .pacing_out5_0(p50), .pacing_out6_0(p60)
    );

    int n_err = 0;
    int n_checks = 0;
    bit chk_on = 0;

    typedef struct { longint a; longint b; bit ha; bit hb; bit t; } ent_t;
    ent_t   mq[$];
    int     mcnt;
    longint committed [7];
    longint slot_v [7];
    bit     slot_d [7];
    bit     exp_aktv [7];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic longint madd(input longint x, input longint y);
        logic signed [65:0] s;
        s = x;
        s = s + y;
`ifdef SATURATE_EN
        if (s > 66'sd9223372036854775807) return SMAX;
        if (s < -66'sd9223372036854775808) return SMIN;
`endif
        return longint'(s[63:0]);
    endfunction

    function automatic longint rd(input int k);
        return slot_d[k] ? slot_v[k] : committed[k];
    endfunction

    function automatic void ev(input int k, input longint v);
        slot_v[k] = v;
        slot_d[k] = 1'b1;
    endfunction

    function automatic void model_slot(input ent_t e);
        for (int k = 0; k < 7; k++) slot_d[k] = 1'b0;
        if (e.ha) ev(0, madd(e.a, rd(4)));
        if (e.hb) ev(1, madd(e.b, rd(0)));
        if (e.ha && e.hb) ev(2, madd(rd(0), rd(1)));
        if (e.ha) ev(3, madd(e.a, rd(6)));
        else if (e.t) ev(3, madd(rd(2), rd(6)));
        if (e.t) begin
            ev(4, madd(rd(3), 64'sd1));
            ev(5, madd(rd(4), rd(4)));
            ev(6, madd(rd(5), rd(1)));
        end
        for (int k = 0; k < 7; k++) begin
            exp_aktv[k] = slot_d[k];
            if (slot_d[k]) committed[k] = slot_v[k];
        end
    endfunction

    // Model: advances one clock per rising edge using the inputs held stable around it.
    initial begin
        mcnt = 0;
        for (int k = 0; k < 7; k++) begin committed[k] = 0; exp_aktv[k] = 0; end
        forever begin
            @(posedge clk);
            if (!rst) begin
                mq.delete();
                mcnt = 0;
                for (int k = 0; k < 7; k++) begin committed[k] = 0; exp_aktv[k] = 0; end
            end else if (!en) begin
                for (int k = 0; k < 7; k++) exp_aktv[k] = 0;
            end else begin
                bit   t;
                ent_t e;
                t = (mcnt == P - 1);
                mcnt = t ? 0 : mcnt + 1;
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    model_slot(e);
                end else begin
                    for (int k = 0; k < 7; k++) exp_aktv[k] = 0;
                end
                if (new_input_0 || new_input_1 || t) begin
                    if (mq.size() < QD) begin
                        e.a = input_0; e.b = input_1;
                        e.ha = new_input_0; e.hb = new_input_1; e.t = t;
                        mq.push_back(e);
                    end
                end
            end
        end
    end

    // Compare: every falling edge, all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            bit t, act, psh, pshv, popv, pa, pb, pt;
            logic [6:0] ea;
            act  = rst && en;
            t    = act && (mcnt == P - 1);
            psh  = act && (new_input_0 || new_input_1 || t);
            popv = act && (mq.size() > 0);
            pshv = psh && ((mq.size() < QD) || popv);
            pa   = popv && mq[0].ha;
            pb   = popv && mq[0].hb;
            pt   = popv && mq[0].t;
            chk("queue_status", {q_push, q_pop, q_push_valid, q_pop_valid},
                {psh, act, pshv, popv});
            chk("pacing", {pin0, pin1, p00, p10, p20, p30, p31, p40, p50, p60},
                {pa, pb, pa, pb, pa && pb, pa, pt, pt, pt, pt});
            for (int k = 0; k < 7; k++) ea[k] = exp_aktv[k] && en;
            chk("aktv", ak, ea);
            for (int k = 0; k < 7; k++)
                chk($sformatf("output_%0d", k), o[k], committed[k]);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit n0, input longint a, input bit n1, input longint b);
        new_input_0 = n0; input_0 = a;
        new_input_1 = n1; input_1 = b;
    endtask

    function automatic longint rval();
        case ($urandom_range(0, 5))
            0:       return SMAX;
            1:       return SMIN;
            2, 3:    return longint'($urandom_range(0, 200)) - 100;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        longint exp_sat;
        rst = 1'b0; en = 1'b1;
        drive(0, 0, 0, 0);
        repeat (3) step();
        chk_on = 1'b1;
        rst = 1'b1;                                   // now in cycle 1
        repeat (10) step();                           // cycle 11
        @(negedge clk);
        chk("idle_q_push", q_push, 1'b0);
        chk("idle_aktv", ak, 7'b0);
        chk("idle_out3", o[3], 64'd0);

        repeat (489) step();                          // cycle 500
        drive(1, 1, 1, 1);
        step(); drive(0, 0, 0, 0);                    // 501: pop
        @(negedge clk);
        chk("pop501_pacing", {pin0, pin1, p00, p10, p20, p30, p31, p40, p50, p60}, 10'b1111110000);
        step();                                       // 502
        @(negedge clk);
        chk("r502_aktv", ak, 7'b0001111);
        chk("r502_vals", {o[0], o[1], o[2], o[3]}, {64'd1, 64'd2, 64'd3, 64'd1});

        repeat (500) step();                          // 1002: tick result
        @(negedge clk);
        chk("tick_aktv", ak, 7'b1111000);
        chk("tick_vals", {o[3], o[4], o[5], o[6]}, {64'd3, 64'd4, 64'd8, 64'd10});

        repeat (8) step(); drive(1, 2, 0, 0);         // 1010
        step(); drive(0, 0, 0, 0);
        step();                                       // 1012
        @(negedge clk);
        chk("a2_aktv", ak, 7'b0001001);
        chk("a2_vals", {o[0], o[3]}, {64'd6, 64'd12});
        repeat (8) step(); drive(0, 0, 1, 4);         // 1020
        step(); drive(0, 0, 0, 0);
        step();
        @(negedge clk);
        chk("b4_aktv", ak, 7'b0000010);
        chk("b4_out1", o[1], 64'd10);

        repeat (8) step(); drive(1, 5, 0, 0);         // 1030
        @(negedge clk);
        chk("pair1_push_valid", q_push_valid, 1'b1);
        step(); drive(0, 0, 0, 0);
        step(); drive(0, 0, 1, 7);                    // 1032
        @(negedge clk);
        chk("pair2_push_valid", q_push_valid, 1'b1);
        chk("pair1_vals", {o[0], o[3]}, {64'd9, 64'd15});
        step(); drive(0, 0, 0, 0);
        step();                                       // 1034
        @(negedge clk);
        chk("pair2_out1", o[1], 64'd16);

`ifdef SATURATE_EN
        exp_sat = SMAX;
`else
        exp_sat = SMIN + 3;
`endif
        repeat (6) step(); drive(1, SMAX, 0, 0);      // 1040
        step(); drive(0, 0, 0, 0);
        step();
        @(negedge clk);
        chk("max_out0", o[0], exp_sat);

        repeat (8) step(); drive(1, 3, 0, 0);         // 1050
        step(); drive(0, 0, 0, 0); rst = 1'b0;        // reset in the pop cycle
        step(); rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_aktv", ak, 7'b0);
        chk("rst_mid_out0", o[0], 64'd0);

        en = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 1), rval(), $urandom_range(0, 1), rval());
            step();
        end
        drive(0, 0, 0, 0);
        en = 1'b1;

        for (int i = 0; i < 6000; i++) begin
            drive($urandom_range(0, 3) == 0, rval(), $urandom_range(0, 3) == 0, rval());
            en  = ($urandom_range(0, 29) != 0);
            rst = ($urandom_range(0, 499) != 0);
            step();
        end
        rst = 1'b1; en = 1'b1;
        drive(0, 0, 0, 0);
        repeat (3) step();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
